// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - SCCB writer shared types, quarter counts and bit selection helpers.
package sccb_pkg;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} sccb_state_t;

  localparam logic [1:0] START_Q    = 2'd3;
  localparam logic [4:0] BITS       = 5'd27;
  localparam logic [1:0] STOP_Q     = 2'd3;
  localparam logic [1:0] DONE_Q     = 2'd1;
  localparam logic [7:0] CAM_ID_DEF = 8'h42;

  function automatic logic ninth_bit(input logic [4:0] c);
    return (c % 5'd9) == 5'd8;
  endfunction

  // Each phase is sent as {byte, 1}; the trailing 1 is the released 9th bit.
  function automatic logic sccb_bit(input logic [7:0] id, input logic [7:0] a,
                                    input logic [7:0] d, input logic [4:0] c);
    logic [8:0] w;
    case (c / 5'd9)
      5'd0:    w = {id, 1'b1};
      5'd1:    w = {a, 1'b1};
      default: w = {d, 1'b1};
    endcase
    w = w << (c % 5'd9);
    return w[8];
  endfunction

endpackage

// File: rtl/sccb_writer_if.sv
// rtl/sccb_writer_if.sv - Request handshake and SCCB pad signals of the SCCB writer.
interface sccb_writer_if;
  logic       i_start;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic       i_siod;
  logic       o_ready;
  logic       o_sioc;
  logic       o_siod;
  logic       o_siod_oe;
  logic       o_nack;

  modport master (output i_start, i_addr, i_data, i_siod,
                  input  o_ready, o_sioc, o_siod, o_siod_oe, o_nack);
  modport slave  (input  i_start, i_addr, i_data, i_siod,
                  output o_ready, o_sioc, o_siod, o_siod_oe, o_nack);
endinterface

// File: rtl/sccb_tick_gen.sv
// rtl/sccb_tick_gen.sv - Quarter-bit strobe every CLK_F/(4*SCCB_F) clocks, restartable by clear.
module sccb_tick_gen #(
  parameter int CLK_F  = 100_000_000,
  parameter int SCCB_F = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int Q = CLK_F / (4 * SCCB_F);
  localparam int W = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [W-1:0] LAST = W'(Q - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sccb_writer.sv
// rtl/sccb_writer.sv - SCCB 3-phase register writer (ID, addr, data); 9th-bit check under SCCB_ACK_CHECK_EN.
module sccb_writer
  import sccb_pkg::*;
#(
  parameter int         CLK_F  = 100_000_000,
  parameter int         SCCB_F = 100_000,
  parameter logic [7:0] CAM_ID = CAM_ID_DEF
) (
  input logic         i_clk,
  input logic         i_rst,
  sccb_writer_if.slave bus
);
  sccb_state_t state;
  logic [1:0]  qtr;
  logic [4:0]  cnt;
  logic [7:0]  addr_q, data_q;
  logic        ready, sioc, siod, oe, nack;
  logic        tick, accept;

  assign accept = ready && bus.i_start;

  sccb_tick_gen #(.CLK_F(CLK_F), .SCCB_F(SCCB_F)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (accept),
    .enable (!ready),
    .tick   (tick)
  );

`ifndef SCCB_ACK_CHECK_EN
  logic unused_siod;
  assign unused_siod = bus.i_siod;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      qtr    <= '0;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      ready  <= 1'b1;
      sioc   <= 1'b1;
      siod   <= 1'b1;
      oe     <= 1'b1;
      nack   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          addr_q <= bus.i_addr;
          data_q <= bus.i_data;
          state  <= S_START;
          qtr    <= '0;
          ready  <= 1'b0;
          sioc   <= 1'b1;
          siod   <= 1'b1;
          oe     <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
          nack   <= 1'b0;
`endif
        end
        S_START: if (tick) begin
          if (qtr == START_Q - 2'd1) begin
            state <= S_BIT;
            qtr   <= '0;
            cnt   <= '0;
            siod  <= sccb_bit(CAM_ID, addr_q, data_q, 5'd0);
          end else begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd0) siod <= 1'b0;
            else             sioc <= 1'b0;
          end
        end
        S_BIT: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd1: sioc <= 1'b1;
            2'd2: begin
`ifdef SCCB_ACK_CHECK_EN
              if (ninth_bit(cnt) && bus.i_siod) nack <= 1'b1;
`endif
            end
            2'd3: begin
              sioc <= 1'b0;
              if (cnt == BITS - 5'd1) begin
                state <= S_STOP;
                siod  <= 1'b0;
                oe    <= 1'b1;
              end else begin
                cnt  <= cnt + 5'd1;
                siod <= sccb_bit(CAM_ID, addr_q, data_q, cnt + 5'd1);
                oe   <= !ninth_bit(cnt + 5'd1);
              end
            end
            default: ;
          endcase
        end
        S_STOP: if (tick) begin
          if (qtr == STOP_Q - 2'd1) begin
            state <= S_DONE;
            qtr   <= '0;
          end else begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd0) sioc <= 1'b1;
            else             siod <= 1'b1;
          end
        end
        S_DONE: if (tick) begin
          if (qtr == DONE_Q - 2'd1) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            qtr <= qtr + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_sioc    = sioc;
  assign bus.o_siod    = siod;
  assign bus.o_siod_oe = oe;
  assign bus.o_nack    = nack;
endmodule

// File: tb/tb_sccb_writer.sv
// tb/tb_sccb_writer.sv - Self-checking bench: default-rate and Q=1 writers against a quarter-level waveform model.
module tb_sccb_writer;
  logic clk, rst, sel;
  logic t_start, t_siod;
  logic [7:0] t_addr, t_data;
  int n_cmp, n_fail;

  sccb_writer_if dbus();
  sccb_writer_if fbus();

  sccb_writer u_def (.i_clk(clk), .i_rst(rst), .bus(dbus));
  sccb_writer #(.CLK_F(400), .SCCB_F(100)) u_fast (.i_clk(clk), .i_rst(rst), .bus(fbus));

  assign dbus.i_start = t_start & ~sel;
  assign fbus.i_start = t_start & sel;
  assign dbus.i_addr  = t_addr;
  assign fbus.i_addr  = t_addr;
  assign dbus.i_data  = t_data;
  assign fbus.i_data  = t_data;
  assign dbus.i_siod  = t_siod;
  assign fbus.i_siod  = t_siod;

  logic m_ready, m_sioc, m_siod, m_oe, m_nack;
  assign m_ready = sel ? fbus.o_ready   : dbus.o_ready;
  assign m_sioc  = sel ? fbus.o_sioc    : dbus.o_sioc;
  assign m_siod  = sel ? fbus.o_siod    : dbus.o_siod;
  assign m_oe    = sel ? fbus.o_siod_oe : dbus.o_siod_oe;
  assign m_nack  = sel ? fbus.o_nack    : dbus.o_nack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, d;
    int         ack;
    logic [7:0] e0, e1, e2;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (m_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("ready_wait", 32'd0, 32'd1);
    t_addr  = a;
    t_data  = d;
    t_start = 1'b1;
    @(posedge clk);
    #1 t_start = 1'b0;
  endtask

  // Expected bus per quarter: START(3), 27 bits x 4 quarters, STOP(3), DONE(1).
  task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input int q,
                         input int ign_at, input int ack_bit,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input string tag);
    logic [2:0] wave[$];
    logic bits[$];
    logic oes[$];
    logic [7:0] got[3];
    int bad, low, starts, stops, k;
    logic ps, pd, exp_nack;
    wave.push_back(3'b111); wave.push_back(3'b101); wave.push_back(3'b001);
    for (int b = 0; b < 27; b++) begin
      logic [7:0] by;
      logic v, o;
      int p;
      by = (b < 9) ? 8'h42 : (b < 18) ? a : d;
      p = b % 9;
      if (p == 8) begin v = 1'b1; o = 1'b0; end
      else begin v = by[7-p]; o = 1'b1; end
      wave.push_back({1'b0, v, o}); wave.push_back({1'b0, v, o});
      wave.push_back({1'b1, v, o}); wave.push_back({1'b1, v, o});
    end
    wave.push_back(3'b001); wave.push_back(3'b101); wave.push_back(3'b111); wave.push_back(3'b111);
`ifdef SCCB_ACK_CHECK_EN
    exp_nack = (ack_bit >= 0);
`else
    exp_nack = 1'b0;
`endif
    start_req(a, d);
    bad = 0; low = 0; starts = 0; stops = 0;
    ps = 1'b1; pd = 1'b1;
    for (int c = 0; c < 115 * q; c++) begin
      @(negedge clk);
      k = c / q;
      if ({m_sioc, m_siod, m_oe} !== wave[k]) bad++;
      if (m_ready === 1'b0) low++;
      if (m_sioc && !ps) begin bits.push_back(m_siod); oes.push_back(m_oe); end
      if (m_sioc && ps && pd && !m_siod) starts++;
      if (m_sioc && ps && !pd && m_siod) stops++;
      ps = m_sioc;
      pd = m_siod;
      t_siod = (ack_bit >= 0) && (k >= 3 + 4 * ack_bit) && (k < 7 + 4 * ack_bit);
      if (c == ign_at) begin t_start = 1'b1; t_addr = ~a; t_data = ~d; end
      if (c == ign_at + 1) t_start = 1'b0;
    end
    t_siod = 1'b0;
    chk({tag, "_wave"}, bad, 0);
    chk({tag, "_busy_len"}, low, 115 * q);
    chk({tag, "_start_cnt"}, starts, 1);
    chk({tag, "_stop_cnt"}, stops, 1);
    chk({tag, "_rises"}, bits.size(), 28);
    if (bits.size() >= 27) begin
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 8; i++) got[j][7-i] = bits[9*j+i];
      chk({tag, "_bytes"}, {8'h0, got[0], got[1], got[2]}, {8'h0, e0, e1, e2});
      chk({tag, "_ninth_oe"}, {oes[8], oes[17], oes[26]}, 3'b000);
    end
    @(negedge clk);
    chk({tag, "_idle"}, {m_ready, m_sioc, m_siod, m_oe}, 4'hF);
    chk({tag, "_nack"}, m_nack, exp_nack);
  endtask

  initial begin
    #1_500_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rd;
    int ab;
    n_cmp = 0; n_fail = 0;
    t_start = 1'b0; t_addr = '0; t_data = '0; t_siod = 1'b0;
    sel = 1'b0; rst = 1'b1;
    vt[0] = '{8'h00, 8'h00, -1, 8'h42, 8'h00, 8'h00};
    vt[1] = '{8'hFF, 8'hFF, -1, 8'h42, 8'hFF, 8'hFF};
    vt[2] = '{8'hAA, 8'h55, -1, 8'h42, 8'hAA, 8'h55};
    vt[3] = '{8'h01, 8'h80, 17, 8'h42, 8'h01, 8'h80};
    vt[4] = '{8'h12, 8'h34, -1, 8'h42, 8'h12, 8'h34};
    #22;
    chk("rst_def", {m_ready, m_sioc, m_siod, m_oe, m_nack}, 5'b11110);
    sel = 1'b1;
    #1 chk("rst_fast", {m_ready, m_sioc, m_siod, m_oe, m_nack}, 5'b11110);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_txn(vt[i].a, vt[i].d, 1, -1, vt[i].ack, vt[i].e0, vt[i].e1, vt[i].e2, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       ab = -1;
        1:       ab = 8;
        2:       ab = 17;
        default: ab = 26;
      endcase
      run_txn(ra, rd, 1, -1, ab, 8'h42, ra, rd, $sformatf("rnd%0d", i));
    end

    sel = 1'b0;
    #1;
    run_txn(8'h12, 8'h80, 250, 1000, -1, 8'h42, 8'h12, 8'h80, "def");
    start_req(8'h77, 8'h66);
    repeat (5000) @(negedge clk);
    chk("busy_before_rst", {m_ready, m_sioc}, 2'b00);
    rst = 1'b1;
    #1 chk("rst_async", {m_ready, m_sioc, m_siod, m_oe, m_nack}, 5'b11110);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_txn(8'h3C, 8'hA5, 250, -1, -1, 8'h42, 8'h3C, 8'hA5, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sccb_writer.md
SCCB_WRITER -- requirements
Module: sccb_writer

Interface
REQ-001 SHALL have parameter CLK_F, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCCB_F, default 100_000, SIOC frequency in Hz.
REQ-003 SHALL have parameter CAM_ID, default 8'h42, camera write ID sent as phase 1.
REQ-004 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_start  input  1  single-cycle write request.
REQ-007 SHALL have port i_addr  input  8  camera register address.
REQ-008 SHALL have port i_data  input  8  register write value.
REQ-009 SHALL have port o_ready  output  1  idle, request will be accepted.
REQ-010 SHALL have port o_sioc  output  1  SCCB clock.
REQ-011 SHALL have port o_siod  output  1  SCCB data value.
REQ-012 SHALL have port o_siod_oe  output  1  1 = drive o_siod, 0 = release.
REQ-013 SHALL have port i_siod  input  1  sampled SIOD pad, used only under SCCB_ACK_CHECK_EN.
REQ-014 SHALL have port o_nack  output  1  last transaction saw a high 9th bit.

Function
REQ-015 SHALL derive a quarter-bit strobe every Q = CLK_F/(4*SCCB_F) clocks (Q = 250 at defaults); the divider restarts at 0 on acceptance.
REQ-016 SHALL accept a request when i_start=1 and o_ready=1, latching i_addr/i_data; o_ready SHALL be 0 from the following edge until completion.
REQ-017 SHALL ignore i_start while o_ready=0, with no effect on latched data or timing.
REQ-018 SHALL use FSM states IDLE, START, BIT, STOP, DONE, all advancing only on quarter strobes except IDLE.
REQ-019 IDLE: o_sioc=1, o_siod=1, o_siod_oe=1, o_ready=1.
REQ-020 START, 3 quarters: q0 sioc=1 siod=1; q1 siod=0; q2 sioc=0.
REQ-021 BIT, 27 bits of 4 quarters, for phases CAM_ID, addr, data, each 8 bits MSB first then a 9th don't-care bit.
REQ-022 Each bit: q0 sioc=0 with siod updated; q1 sioc=0; q2,q3 sioc=1; siod stable from q1 through q3.
REQ-023 9th bit SHALL have o_siod_oe=0 and o_siod=1.
REQ-024 STOP, 3 quarters: q0 sioc=0 siod=0; q1 sioc=1; q2 siod=1.
REQ-025 DONE SHALL last 1 quarter (bus-free gap), then enter IDLE with o_ready=1.
REQ-026 o_ready SHALL return to 1 exactly 115*Q clocks after the acceptance edge.
REQ-027 Bit counter SHALL be 5 bits (0..26); phase select = count/9, bit index = 8 - count%9.
REQ-028 A request accepted on the same edge that o_ready rises SHALL start a new transaction immediately.

Reset
REQ-029 While i_rst=1, outputs SHALL be o_ready=1, o_sioc=1, o_siod=1, o_siod_oe=1, o_nack=0, state IDLE, and divider and counters 0.
REQ-030 Reset mid-transaction SHALL abort immediately, with no STOP generated and the bus released high asynchronously.

Configuration
REQ-031 With SCCB_ACK_CHECK_EN defined, i_siod SHALL be sampled at the q2 strobe of each 9th bit; o_nack SHALL clear on acceptance and set if any sample is 1.
REQ-032 Without SCCB_ACK_CHECK_EN, i_siod is unused, o_nack is tied 0, and timing is identical.

Structure
REQ-033 Package sccb_pkg SHALL hold the FSM state typedef, quarter counts (START_Q=3, BITS=27, STOP_Q=3, DONE_Q=1) and the CAM_ID default.
REQ-034 Sub-module sccb_tick_gen SHALL generate the quarter strobe (params CLK_F, SCCB_F; inputs clear and enable).

Verification
REQ-035 Defaults, i_addr=8'h12, i_data=8'h80: bits decoded at SIOC rising edges SHALL be 42,12,80; o_ready low for 28750 clocks.
REQ-036 Each 9th bit SHALL show o_siod_oe=0; START (SIOD fall, SIOC high) and STOP (SIOD rise, SIOC high) SHALL appear exactly once.
REQ-037 A second i_start 1000 clocks into a transaction SHALL be ignored, with the decoded bytes equal to the first request only.
REQ-038 i_rst pulsed at clock 5000 of a transaction SHALL take outputs to idle within the same cycle; a new request after reset SHALL complete normally.
REQ-039 SCCB_ACK_CHECK_EN, i_siod held 1 in the addr 9th bit: o_nack=1 at completion; the next request with i_siod=0 SHALL give o_nack=0.
REQ-040 CLK_F=400, SCCB_F=100 (Q=1): back-to-back starts on each o_ready rise SHALL give 115-clock transactions with no gap errors.
